// File: rtl/input_conditioner.sv
// input_conditioner: per-channel button/switch conditioning.
// Each raw input is synchronised, normalised to 1 = pressed, debounced over
// DB_COUNT sampling ticks, and turned into a single-cycle pulse plus a sticky
// pending flag that is cleared by ack.
// Optional feature: define INPUT_CONDITIONER_AUTOREPEAT_EN to compile in
// auto-repeat (first repeat after REPEAT_DELAY ticks, then every
// REPEAT_PERIOD ticks while held). Without it, REPEAT_* are ignored.
module input_conditioner #(
  parameter int CHANNELS      = 2,
  parameter int DB_COUNT      = 50000,
  parameter int ACTIVE_LOW    = 1,
  parameter int EDGE_MODE     = 0,
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 100
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                tick,
  input  logic [CHANNELS-1:0] raw_in,
  input  logic [CHANNELS-1:0] ack,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] pulse,
  output logic [CHANNELS-1:0] pending
);

  localparam int CW = $clog2(DB_COUNT + 1);
  // Raw-domain value that means "not pressed" for the configured polarity.
  localparam logic [CHANNELS-1:0] IDLE_RAW = (ACTIVE_LOW != 0) ? '1 : '0;

  // Elaboration-time parameter range checks.
  if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
    $error("input_conditioner: CHANNELS out of range 1..16");
  end
  if (DB_COUNT < 1 || DB_COUNT > (1 << 20)) begin : g_bad_db_count
    $error("input_conditioner: DB_COUNT out of range 1..2^20");
  end
  if (EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_bad_edge_mode
    $error("input_conditioner: EDGE_MODE must be 0, 1 or 2");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("input_conditioner: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  logic [CHANNELS-1:0] sync1;
  logic [CHANNELS-1:0] sync2;
  logic [CHANNELS-1:0] s;
  logic [CHANNELS-1:0] level_d;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;
  logic [CHANNELS-1:0] edge_ev;
  logic [CHANNELS-1:0] rep_hit;
  logic [CW-1:0]       cnt [CHANNELS];

  // Two-flop synchroniser; reset parks it at the idle (not pressed) level.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= IDLE_RAW;
      sync2 <= IDLE_RAW;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
    end
  end

  assign s = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

  // Debounce: count ticks while s disagrees with level, accept on DB_COUNT.
  always_ff @(posedge clock) begin
    if (reset) begin
      level <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (s[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (tick) begin
          if (cnt[i] == CW'(DB_COUNT - 1)) begin
            level[i] <= s[i];
            cnt[i]   <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  // Edge selection according to EDGE_MODE.
  always_comb begin
    rise    = level & ~level_d;
    fall    = ~level & level_d;
    edge_ev = '0;
    case (EDGE_MODE)
      0:       edge_ev = rise;
      1:       edge_ev = fall;
      default: edge_ev = rise | fall;
    endcase
  end

`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0]       rcnt [CHANNELS];
  logic [CHANNELS-1:0] periodic;

  // Repeat strobe: counter measures ticks since the press pulse (level_d
  // rises with the pulse), first against the delay, then against the period.
  always_comb begin
    rep_hit = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (EDGE_MODE != 1 && level[i] && level_d[i] && tick) begin
        rep_hit[i] = (rcnt[i] == (periodic[i] ? RW'(REPEAT_PERIOD - 1)
                                              : RW'(REPEAT_DELAY - 1)));
      end
    end
  end

  // Repeat counter: cleared while released, restarted on every repeat strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      periodic <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) rcnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (!level_d[i] || EDGE_MODE == 1) begin
          rcnt[i]     <= '0;
          periodic[i] <= 1'b0;
        end else if (rep_hit[i]) begin
          rcnt[i]     <= '0;
          periodic[i] <= 1'b1;
        end else if (tick && level[i]) begin
          rcnt[i] <= rcnt[i] + 1'b1;
        end
      end
    end
  end
`else
  assign rep_hit = '0;
`endif

  // Registered strobe and sticky flag; a new pulse beats a same-cycle ack.
  always_ff @(posedge clock) begin
    if (reset) begin
      level_d <= '0;
      pulse   <= '0;
      pending <= '0;
    end else begin
      level_d <= level;
      pulse   <= edge_ev | rep_hit;
      pending <= pulse | (pending & ~ack);
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Randomised scoreboard bench for input_conditioner. The stimulus process
// drives inputs on the falling edge, steps a behavioural model for the coming
// rising edge and queues the expected outputs; the monitor pops and compares
// shortly after each rising edge.
module tb_input_conditioner;

  localparam int CH  = 3;
  localparam int DB  = 4;
  localparam int AL  = 1;
  localparam int EM  = 2;
  localparam int RD  = 8;
  localparam int RP  = 3;
  localparam int NCYC = 4000;
`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  typedef struct packed {
    logic [CH-1:0] lvl;
    logic [CH-1:0] pls;
    logic [CH-1:0] pnd;
  } exp_t;

  logic          clock = 1'b1;
  logic          reset;
  logic          tick;
  logic [CH-1:0] raw_in;
  logic [CH-1:0] ack;
  logic [CH-1:0] level;
  logic [CH-1:0] pulse;
  logic [CH-1:0] pending;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Model state: plain integers per channel.
  int m_s1[CH], m_s2[CH], m_lvl[CH], m_prev[CH], m_pulse[CH], m_pend[CH];
  int m_stable[CH], m_held[CH], hold[CH];

  input_conditioner #(
    .CHANNELS(CH), .DB_COUNT(DB), .ACTIVE_LOW(AL), .EDGE_MODE(EM),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clock(clock), .reset(reset), .tick(tick), .raw_in(raw_in), .ack(ack),
    .level(level), .pulse(pulse), .pending(pending)
  );

  always #5 clock = ~clock;

  task automatic model_step();
    exp_t e;
    for (int c = 0; c < CH; c++) begin
      if (reset) begin
        m_s1[c] = AL; m_s2[c] = AL;
        m_lvl[c] = 0; m_prev[c] = 0; m_pulse[c] = 0; m_pend[c] = 0;
        m_stable[c] = 0; m_held[c] = 0;
      end else begin
        int pressed, old_lvl, old_prev, old_pulse, rising, falling, rep, n;
        pressed   = (AL != 0) ? (m_s2[c] == 0) : (m_s2[c] != 0);
        old_lvl   = m_lvl[c];
        old_prev  = m_prev[c];
        old_pulse = m_pulse[c];
        rising    = old_lvl && !old_prev;
        falling   = !old_lvl && old_prev;
        // Auto-repeat: n-th tick after the press pulse; fire at RD, RD+RP, ...
        rep = 0;
        if (AUTO && EM != 1 && old_lvl && old_prev && tick) begin
          n   = m_held[c] + 1;
          rep = (n == RD) || (n > RD && ((n - RD) % RP) == 0);
        end
        if (!old_prev) m_held[c] = 0;
        else if (tick) m_held[c]++;
        m_pulse[c] = ((rising && EM != 1) || (falling && EM != 0) || rep) ? 1 : 0;
        m_pend[c]  = (old_pulse || (m_pend[c] && !ack[c])) ? 1 : 0;
        if (pressed == old_lvl) begin
          m_stable[c] = 0;
        end else if (tick) begin
          m_stable[c]++;
          if (m_stable[c] == DB) begin
            m_lvl[c]    = pressed;
            m_stable[c] = 0;
          end
        end
        m_prev[c] = old_lvl;
        m_s2[c]   = m_s1[c];
        m_s1[c]   = raw_in[c];
      end
      e.lvl[c] = (m_lvl[c] != 0);
      e.pls[c] = (m_pulse[c] != 0);
      e.pnd[c] = (m_pend[c] != 0);
    end
    exp_q.push_back(e);
  endtask

  // Stimulus: random hold lengths give both glitches and accepted presses;
  // alternating phases run tick every cycle or roughly one cycle in four.
  initial begin
    reset  = 1'b1;
    tick   = 1'b1;
    raw_in = '1;
    ack    = '0;
    for (int c = 0; c < CH; c++) hold[c] = 0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clock);
      reset = (cyc < 3) || ($urandom_range(0, 399) == 0);
      tick  = (((cyc / 500) % 2) == 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
      for (int c = 0; c < CH; c++) begin
        if (hold[c] == 0) begin
          raw_in[c] = $urandom_range(0, 1);
          hold[c]   = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 5)
                                                  : $urandom_range(6, 45);
        end
        hold[c]--;
        ack[c] = ($urandom_range(0, 3) == 0);
      end
      model_step();
    end
    @(posedge clock);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d queued entries, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Monitor: outputs are valid every cycle, so one entry is consumed per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL queue: got empty scoreboard, want an entry at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        if (level !== e.lvl) begin
          bad++;
          $display("FAIL level: got %b want %b at %0t", level, e.lvl, $time);
        end
        total++;
        if (pulse !== e.pls) begin
          bad++;
          $display("FAIL pulse: got %b want %b at %0t", pulse, e.pls, $time);
        end
        total++;
        if (pending !== e.pnd) begin
          bad++;
          $display("FAIL pending: got %b want %b at %0t", pending, e.pnd, $time);
        end
      end
    end
  end

endmodule
